pixel_iterator: RTL and testbench

- Mandelbrot escape-time engine that sits directly upstream of the VGA SRAM pixel writer.
- Walks `range` consecutive pixels along one row, starting at c = (`cr_init`, `ci_init`) and stepping the real part by `cr_step`.
- For each pixel it produces an iteration count and the final z, raises `done`, and waits for the writer's `handshake` before moving to the next pixel.
- After the last pixel is consumed it raises a sticky `all_done`.

---
 rtl/pixel_iterator.sv | 232 +++++++++++++++++++++++
 tb/tb_pixel_iterator.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_iterator.sv
// pixel_iterator: Mandelbrot escape-time engine for one row of pixels.
// Walks `range` pixels starting at c = (cr_init, ci_init), stepping the real
// part by cr_step, and presents each pixel's iteration count and final z.
// Optional feature macro: ITER_CARDIOID_EN adds a two-cycle CHECK stage that
// short-circuits points inside the main cardioid or the period-2 bulb.
// Handshake: `done` is the valid flag for iterations/final_zr/final_zi; the
// writer answers with `handshake` (ready). A result transfers on the edge
// where done=1 and handshake=1; done falls on that same edge and the result
// is never repeated. handshake outside HOLD has no effect.
// dbg_state exposes the FSM state for observation.
module pixel_iterator #(
  parameter int W    = 27,
  parameter int FRAC = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] ci_init,
  input  logic signed [W-1:0] cr_init,
  input  logic signed [W-1:0] cr_step,
  input  logic [31:0]         max_iterations,
  input  logic [31:0]         range,
  input  logic                handshake,
  output logic [31:0]         iterations,
  output logic signed [W-1:0] final_zr,
  output logic signed [W-1:0] final_zi,
  output logic                done,
  output logic                all_done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_CHECK1 = 3'd1,
    S_CHECK2 = 3'd2,
    S_ITER   = 3'd3,
    S_HOLD   = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  localparam logic signed [W-1:0] TWO  = W'(2 ** (FRAC + 1));
  localparam logic signed [W:0]   FOUR = (W + 1)'(2 ** (FRAC + 2));

  state_e               state_q, state_d;
  logic [31:0]          idx_q, idx_d;
  logic signed [W-1:0]  cr_q, cr_d, ci_q, ci_d, step_q, step_d;
  logic [31:0]          max_q, max_d, range_q, range_d;
  logic signed [W-1:0]  zr_q, zr_d, zi_q, zi_d;
  logic [31:0]          count_q, count_d, iter_q, iter_d;
  logic signed [W-1:0]  fzr_q, fzr_d, fzi_q, fzi_d;
  logic                 done_q, done_d, all_done_q, all_done_d;

  // Full-width signed products, rescaled by FRAC and truncated back to W.
  logic signed [2*W-1:0] zr_w, zi_w;
  logic signed [W-1:0]   zr2, zi2, zrzi, zrzi2;
  logic signed [W:0]     mag2;
  logic                  escape;

  assign zr_w   = {{W{zr_q[W-1]}}, zr_q};
  assign zi_w   = {{W{zi_q[W-1]}}, zi_q};
  assign zr2    = W'((zr_w * zr_w) >>> FRAC);
  assign zi2    = W'((zi_w * zi_w) >>> FRAC);
  assign zrzi   = W'((zr_w * zi_w) >>> FRAC);
  assign zrzi2  = zrzi <<< 1;
  assign mag2   = {zr2[W-1], zr2} + {zi2[W-1], zi2};
  assign escape = (zr_q > TWO) || (zr_q < -TWO) || (zi_q > TWO) || (zi_q < -TWO) ||
                  (mag2 > FOUR) || (count_q == max_q);

`ifdef ITER_CARDIOID_EN
  localparam int CW = W + 6;
  localparam logic signed [CW-1:0] QUARTER   = CW'(2 ** (FRAC - 2));
  localparam logic signed [CW-1:0] ONE       = CW'(2 ** FRAC);
  localparam logic signed [CW-1:0] SIXTEENTH = CW'(2 ** (FRAC - 4));

  logic signed [CW-1:0]   cr_x, ci_x, xr, yr, xr2, yr2, ci2, qx, qq;
  logic signed [2*CW-1:0] xr_w, yr_w, ci_w, q_w, qx_w;
  logic signed [CW-1:0]   q_d, q_q, bulb_d, bulb_q, ci2_d, ci2_q;
  logic                   in_region;

  assign cr_x   = {{(CW - W){cr_q[W-1]}}, cr_q};
  assign ci_x   = {{(CW - W){ci_q[W-1]}}, ci_q};
  assign xr     = cr_x - QUARTER;
  assign yr     = cr_x + ONE;
  assign xr_w   = {{CW{xr[CW-1]}}, xr};
  assign yr_w   = {{CW{yr[CW-1]}}, yr};
  assign ci_w   = {{CW{ci_x[CW-1]}}, ci_x};
  assign xr2    = CW'((xr_w * xr_w) >>> FRAC);
  assign yr2    = CW'((yr_w * yr_w) >>> FRAC);
  assign ci2    = CW'((ci_w * ci_w) >>> FRAC);
  assign q_d    = xr2 + ci2;
  assign bulb_d = yr2 + ci2;
  assign ci2_d  = ci2;
  assign qx     = q_q + xr;
  assign q_w    = {{CW{q_q[CW-1]}}, q_q};
  assign qx_w   = {{CW{qx[CW-1]}}, qx};
  assign qq     = CW'((q_w * qx_w) >>> FRAC);
  assign in_region = (qq < (ci2_q >>> 2)) || (bulb_q < SIXTEENTH);

  // Cardioid/bulb intermediates computed in the first CHECK cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q    <= '0;
      bulb_q <= '0;
      ci2_q  <= '0;
    end else begin
      q_q    <= q_d;
      bulb_q <= bulb_d;
      ci2_q  <= ci2_d;
    end
  end
`endif

  // Next-state and registered-output logic of the pixel FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cr_d       = cr_q;
    ci_d       = ci_q;
    step_d     = step_q;
    max_d      = max_q;
    range_d    = range_q;
    zr_d       = zr_q;
    zi_d       = zi_q;
    count_d    = count_q;
    iter_d     = iter_q;
    fzr_d      = fzr_q;
    fzi_d      = fzi_q;
    done_d     = done_q;
    all_done_d = all_done_q;
    case (state_q)
      S_LOAD: begin
        zr_d    = '0;
        zi_d    = '0;
        count_d = '0;
        if (idx_q >= range_q) begin
          state_d    = S_FIN;
          all_done_d = 1'b1;
        end else begin
`ifdef ITER_CARDIOID_EN
          state_d = S_CHECK1;
`else
          state_d = S_ITER;
`endif
        end
      end
`ifdef ITER_CARDIOID_EN
      S_CHECK1: state_d = S_CHECK2;
      S_CHECK2: begin
        if (in_region) begin
          iter_d  = max_q;
          fzr_d   = '0;
          fzi_d   = '0;
          done_d  = 1'b1;
          state_d = S_HOLD;
        end else begin
          state_d = S_ITER;
        end
      end
`endif
      S_ITER: begin
        if (escape) begin
          iter_d  = count_q;
          fzr_d   = zr_q;
          fzi_d   = zi_q;
          done_d  = 1'b1;
          state_d = S_HOLD;
        end else begin
          zr_d    = zr2 - zi2 + cr_q;
          zi_d    = zrzi2 + ci_q;
          count_d = count_q + 32'd1;
        end
      end
      S_HOLD: begin
        if (handshake) begin
          done_d  = 1'b0;
          idx_d   = idx_q + 32'd1;
          cr_d    = cr_q + step_q;
          state_d = S_LOAD;
        end
      end
      S_FIN: begin
        done_d     = 1'b0;
        all_done_d = 1'b1;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State registers; inputs are re-captured every cycle while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      cr_q       <= cr_init;
      ci_q       <= ci_init;
      step_q     <= cr_step;
      max_q      <= max_iterations;
      range_q    <= range;
      zr_q       <= '0;
      zi_q       <= '0;
      count_q    <= '0;
      iter_q     <= '0;
      fzr_q      <= '0;
      fzi_q      <= '0;
      done_q     <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cr_q       <= cr_d;
      ci_q       <= ci_d;
      step_q     <= step_d;
      max_q      <= max_d;
      range_q    <= range_d;
      zr_q       <= zr_d;
      zi_q       <= zi_d;
      count_q    <= count_d;
      iter_q     <= iter_d;
      fzr_q      <= fzr_d;
      fzi_q      <= fzi_d;
      done_q     <= done_d;
      all_done_q <= all_done_d;
    end
  end

  assign iterations = iter_q;
  assign final_zr   = fzr_q;
  assign final_zi   = fzi_q;
  assign done       = done_q;
  assign all_done   = all_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pixel_iterator.sv
// tb_pixel_iterator: table-driven vectors plus randomized rows checked
// against a fixed-point escape-time reference model.
module tb_pixel_iterator;

  localparam int     W    = 27;
  localparam int     FRAC = 23;
  localparam longint ONE  = 64'sd1 <<< FRAC;
  localparam longint TWO  = 2 * ONE;
  localparam longint FOUR = 4 * ONE;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic signed [W-1:0] ci_init = '0;
  logic signed [W-1:0] cr_init = '0;
  logic signed [W-1:0] cr_step = '0;
  logic [31:0]         max_iterations = '0;
  logic [31:0]         range = '0;
  logic                handshake = 1'b0;
  logic [31:0]         iterations;
  logic signed [W-1:0] final_zr;
  logic signed [W-1:0] final_zi;
  logic                done;
  logic                all_done;
  logic [2:0]          dbg_state;

  pixel_iterator #(.W(W), .FRAC(FRAC)) dut (
    .clk            (clk),
    .rst            (rst),
    .ci_init        (ci_init),
    .cr_init        (cr_init),
    .cr_step        (cr_step),
    .max_iterations (max_iterations),
    .range          (range),
    .handshake      (handshake),
    .iterations     (iterations),
    .final_zr       (final_zr),
    .final_zi       (final_zi),
    .done           (done),
    .all_done       (all_done),
    .dbg_state      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic longint wrapw(input longint v);
    longint m;
    m = v & ((64'sd1 <<< W) - 1);
    if (m >= (64'sd1 <<< (W - 1))) m = m - (64'sd1 <<< W);
    return m;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return wrapw((a * b) >>> FRAC);
  endfunction

  function automatic void model(input longint cr, input longint ci, input longint mx,
                                output longint it, output longint zr, output longint zi);
    longint a, b, a2, b2, t, n;
    a = 0; b = 0; n = 0;
    while (1) begin
      a2 = fmul(a, a);
      b2 = fmul(b, b);
      if (a > TWO || a < -TWO || b > TWO || b < -TWO || (a2 + b2) > FOUR || n == mx) break;
      t = wrapw(a2 - b2 + cr);
      b = wrapw(wrapw(2 * fmul(a, b)) + ci);
      a = t;
      n++;
    end
    it = n; zr = a; zi = b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input longint cr, input longint ci, input longint step,
                          input longint mx, input longint rg);
    @(negedge clk);
    rst            = 1'b0;
    handshake      = 1'b0;
    cr_init        = W'(cr);
    ci_init        = W'(ci);
    cr_step        = W'(step);
    max_iterations = 32'(mx);
    range          = 32'(rg);
    cycle();
    chk("rst_iterations", iterations, 0);
    chk("rst_final_zr", final_zr, 0);
    chk("rst_final_zi", final_zi, 0);
    chk("rst_done", done, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_state_load", dbg_state, 0);
    rst = 1'b1;
  endtask

  // Counts edges until done; starts at the negedge before the LOAD edge.
  task automatic wait_done(input string name, input longint exp_lat, input int stray_at,
                           output bit ok);
    int cyc;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < exp_lat + 20) begin
      if (stray_at != 0 && cyc == stray_at) handshake = 1'b1;
      cycle();
      handshake = 1'b0;
      cyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_latency"}, ok ? cyc : -1, exp_lat);
  endtask

  task automatic check_out(input string name, input longint it, input longint zr, input longint zi);
    chk({name, "_done"}, done, 1);
    chk({name, "_iterations"}, iterations, it);
    chk({name, "_final_zr"}, final_zr, zr);
    chk({name, "_final_zi"}, final_zi, zi);
  endtask

  // Hold the result for `hold` cycles, then pulse handshake for one cycle.
  task automatic consume(input string name, input longint it, input longint zr, input longint zi,
                         input int hold, input bit last);
    repeat (hold) begin
      cycle();
      chk({name, "_hold_done"}, done, 1);
      chk({name, "_hold_iterations"}, iterations, it);
      chk({name, "_hold_zr"}, final_zr, zr);
      chk({name, "_hold_zi"}, final_zi, zi);
    end
    handshake = 1'b1;
    cycle();
    handshake = 1'b0;
    chk({name, "_done_fall"}, done, 0);
    if (last) begin
      chk({name, "_all_done_early"}, all_done, 0);
      cycle();
      chk({name, "_all_done_rise"}, all_done, 1);
      chk({name, "_fin_done"}, done, 0);
      handshake = 1'b1;
      cycle();
      handshake = 1'b0;
      cycle();
      chk({name, "_fin_sticky"}, all_done, 1);
      chk({name, "_fin_no_done"}, done, 0);
    end
  endtask

  // Runs a whole row against the model; abort_px >= 0 resets mid-pixel.
  task automatic run_row(input string name, input longint cr, input longint ci,
                         input longint step, input longint mx, input longint rg,
                         input int hold, input int abort_px);
    longint it, zr, zi, c;
    bit ok;
    do_reset(cr, ci, step, mx, rg);
    if (rg == 0) begin
      cycle();
      chk({name, "_empty_all_done"}, all_done, 1);
      repeat (3) begin
        cycle();
        chk({name, "_empty_no_done"}, done, 0);
      end
      return;
    end
    for (int k = 0; k < rg; k++) begin
      if (k == abort_px) begin
        repeat (5) cycle();
        rst = 1'b0;
        cycle();
        chk({name, "_abort_iterations"}, iterations, 0);
        chk({name, "_abort_zr"}, final_zr, 0);
        chk({name, "_abort_zi"}, final_zi, 0);
        chk({name, "_abort_done"}, done, 0);
        chk({name, "_abort_all_done"}, all_done, 0);
        chk({name, "_abort_state"}, dbg_state, 0);
        rst = 1'b1;
        return;
      end
      c = wrapw(cr + k * step);
      model(c, ci, mx, it, zr, zi);
      wait_done($sformatf("%s_px%0d", name, k), it + 2, 0, ok);
      if (!ok) return;
      check_out($sformatf("%s_px%0d", name, k), it, zr, zi);
      consume($sformatf("%s_px%0d", name, k), it, zr, zi, hold, k == rg - 1);
    end
  endtask

  // ---------------- table of single-pixel vectors ----------------
  typedef struct {
    longint cr;
    longint ci;
    longint mx;
    int     hold;
    int     stray;
    longint e_it;
    longint e_zr;
    longint e_zi;
  } vec_t;

  vec_t tab[11];

  initial begin
    bit ok;
    tab[0]  = '{0,         0,         100, 1,  0,  100, 0,        0};
    tab[1]  = '{20971520,  0,         50,  50, 0,  1,   20971520, 0};
    tab[2]  = '{-16777216, 0,         20,  0,  0,  20,  16777216, 0};
    tab[3]  = '{-8388608,  0,         20,  1,  0,  20,  0,        0};
    tab[4]  = '{0,         20971520,  10,  0,  0,  1,   0,        20971520};
    tab[5]  = '{12582912,  12582912,  10,  0,  0,  1,   12582912, 12582912};
    tab[6]  = '{0,         0,         0,   0,  0,  0,   0,        0};
    tab[7]  = '{16777216,  0,         10,  2,  0,  2,   50331648, 0};
    tab[8]  = '{8388608,   0,         10,  0,  0,  3,   41943040, 0};
    tab[9]  = '{0,         0,         100, 2,  30, 100, 0,        0};
    tab[10] = '{0,         -20971520, 10,  0,  0,  1,   0,        -20971520};

    for (int i = 0; i < 11; i++) begin
      do_reset(tab[i].cr, tab[i].ci, 0, tab[i].mx, 1);
      wait_done($sformatf("tab%0d", i), tab[i].e_it + 2, tab[i].stray, ok);
      if (ok) begin
        check_out($sformatf("tab%0d", i), tab[i].e_it, tab[i].e_zr, tab[i].e_zi);
        consume($sformatf("tab%0d", i), tab[i].e_it, tab[i].e_zr, tab[i].e_zi, tab[i].hold, 1'b1);
      end
    end

    // Three pixels along the real axis: c = -2, -1.5, -1, all bounded.
    run_row("row3", -16777216, 0, 4194304, 20, 3, 1, -1);
    // Empty row: straight to all_done without a done pulse.
    run_row("empty", 0, 0, 0, 20, 0, 0, -1);
    // Reset mid-ITER on pixel 2 of 4, then the full row from pixel 0.
    run_row("abort", -8388608, 0, 2097152, 20, 4, 0, 2);
    run_row("restart", -8388608, 0, 2097152, 20, 4, 0, -1);
    // Back-to-back consumption with an immediate handshake.
    run_row("b2b", 20971520, 0, 0, 5, 3, 0, -1);

    // Randomized rows.
    for (int r = 0; r < 10; r++) begin
      longint cr, ci, step, mx, rg;
      int hold;
      cr   = longint'($urandom_range(0, 26004685)) - 18454938;
      ci   = longint'($urandom_range(0, 20132659)) - 10066330;
      step = longint'($urandom_range(0, 3355443));
      mx   = longint'($urandom_range(1, 40));
      rg   = longint'($urandom_range(1, 4));
      hold = int'($urandom_range(0, 3));
      run_row($sformatf("rnd%0d", r), cr, ci, step, mx, rg, hold, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
